// File: rtl/mlp_layer_sequencer.sv
// ---------------------------------------------------------------------------
// mlp_layer_sequencer
//
// Walks a binary-MLP frame through NUM_LAYERS weight layers, one output neuron
// at a time. For each neuron it streams n_in operand/weight read addresses and
// raises mac_en one cycle later to match the memory read latency. It then
// writes the neuron result back to the register file, or presents it on
// out_valid/out_idx for the final layer. Frame starts use a
// frame_ready/busy/done handshake, a one-deep pending request and a minimum
// start-to-start spacing of FRAME_GAP cycles.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous reset, active high
//   frame_ready_i  DMEM holds a complete frame at frame_base_i
//   frame_base_i   DMEM base of that frame, latched on accept
//   busy_o         frame in progress
//   done_o         one-cycle pulse when a frame completes
//   layer_o        current weight layer (0-based), 0 when idle
//   dmem_addr_o    input operand address (layer 0)
//   rf_raddr_o     operand address (layers > 0), qualified by rf_ren_o
//   rf_ren_o       register file read enable
//   wmem_addr_o    weight address, contiguous across all layers
//   mac_en_o       operand and weight valid at the datapath this cycle
//   acc_clr_o      clear the neuron accumulator
//   rf_wen_o       write neuron result at rf_waddr_o
//   rf_waddr_o     result address
//   out_valid_o    final-layer neuron result valid
//   out_idx_o      final-layer neuron index
// ---------------------------------------------------------------------------
module mlp_layer_sequencer #(
    parameter int NUM_LAYERS = 4,
    parameter int SIZE_W     = 8,
    parameter logic [SIZE_W*(NUM_LAYERS+1)-1:0] LAYER_SIZES = {8'd2, 8'd11, 8'd24, 8'd60, 8'd48},
    parameter int RF_AW      = 7,
    parameter int DM_AW      = 7,
    parameter int WM_AW      = 13,
    parameter int FRAME_GAP  = 5000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             frame_ready_i,
    input  logic [DM_AW-1:0] frame_base_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [2:0]       layer_o,
    output logic [DM_AW-1:0] dmem_addr_o,
    output logic [RF_AW-1:0] rf_raddr_o,
    output logic             rf_ren_o,
    output logic [WM_AW-1:0] wmem_addr_o,
    output logic             mac_en_o,
    output logic             acc_clr_o,
    output logic             rf_wen_o,
    output logic [RF_AW-1:0] rf_waddr_o,
    output logic             out_valid_o,
    output logic [7:0]       out_idx_o
);

    // Gap counter only ever holds FRAME_GAP-1 or less.
    localparam int                 GAP_W    = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(FRAME_GAP - 1);
    localparam logic [2:0]         LAST     = 3'(NUM_LAYERS - 1);
    localparam logic [RF_AW-1:0]   RF_HALF  = {1'b1, {(RF_AW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ACC, S_DRAIN, S_WB, S_CLR, S_DONE
    } state_t;

    // Unpack the layer size table; slots beyond NUM_LAYERS are never indexed.
    logic [SIZE_W-1:0] size_tab [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_size
            if (gi <= NUM_LAYERS) begin : g_used
                assign size_tab[gi] = LAYER_SIZES[gi*SIZE_W +: SIZE_W];
                // A zero-sized layer would make the == terminal counts never match.
                a_size_nonzero: assert property (@(posedge clk_i) size_tab[gi] != '0);
            end else begin : g_unused
                assign size_tab[gi] = '0;
            end
        end
    endgenerate

    state_t            state_q, state_d;
    logic [2:0]        layer_q, layer_d;
    logic [SIZE_W-1:0] i_q, i_d, j_q, j_d;
    logic [WM_AW-1:0]  wmem_q, wmem_d;
    logic [DM_AW-1:0]  base_q, base_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              pending_q, pending_d;
    logic              mac_en_q;

    logic [SIZE_W-1:0] n_in, n_out, i_inc, j_inc;
    logic [RF_AW-1:0]  in_base, out_base;
    logic              last_layer, accept, issue;

    assign n_in       = size_tab[layer_q];
    assign n_out      = size_tab[layer_q + 3'd1];
    assign i_inc      = i_q + SIZE_W'(1);
    assign j_inc      = j_q + SIZE_W'(1);
    assign last_layer = (layer_q == LAST);
    assign accept     = (state_q == S_IDLE) && (frame_ready_i || pending_q) && (gap_q == '0);
    assign issue      = (state_q == S_ACC);

    // Layers ping-pong between the RF halves: even layers write the lower
    // half, odd layers the upper; each layer reads what the previous wrote.
    assign in_base  = layer_q[0] ? '0 : RF_HALF;
    assign out_base = layer_q[0] ? RF_HALF : '0;

    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        i_d       = i_q;
        j_d       = j_q;
        wmem_d    = wmem_q;
        base_d    = base_q;
        // A request that is not accepted right away is remembered once;
        // accepting consumes both the stored and any concurrent request.
        pending_d = accept ? 1'b0 : (pending_q | frame_ready_i);
        gap_d     = accept ? GAP_LOAD : ((gap_q == '0) ? '0 : gap_q - GAP_W'(1));

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                    base_d  = frame_base_i;
                    layer_d = '0;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            S_START: state_d = S_ACC;
            S_ACC: begin
                wmem_d = wmem_q + WM_AW'(1);
                if (i_inc == n_in) begin
                    i_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    i_d = i_inc;
                end
            end
            S_DRAIN: state_d = S_WB;
            S_WB:    state_d = S_CLR;
            S_CLR: begin
                if (j_inc == n_out) begin
                    j_d = '0;
                    if (last_layer) begin
                        layer_d = '0;
                        wmem_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        layer_d = layer_q + 3'd1;
                        state_d = S_ACC;
                    end
                end else begin
                    j_d     = j_inc;
                    state_d = S_ACC;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            layer_q   <= '0;
            i_q       <= '0;
            j_q       <= '0;
            wmem_q    <= '0;
            base_q    <= '0;
            gap_q     <= '0;
            pending_q <= 1'b0;
            mac_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            layer_q   <= layer_d;
            i_q       <= i_d;
            j_q       <= j_d;
            wmem_q    <= wmem_d;
            base_q    <= base_d;
            gap_q     <= gap_d;
            pending_q <= pending_d;
            // Operands arrive one cycle after their address is issued.
            mac_en_q  <= issue;
        end
    end

    assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o      = (state_q == S_DONE);
    assign layer_o     = layer_q;
    assign dmem_addr_o = (issue && (layer_q == 3'd0)) ? base_q + DM_AW'(i_q) : '0;
    assign rf_ren_o    = issue && (layer_q != 3'd0);
    assign rf_raddr_o  = rf_ren_o ? in_base + RF_AW'(i_q) : '0;
    assign wmem_addr_o = wmem_q;
    assign mac_en_o    = mac_en_q;
    assign acc_clr_o   = (state_q == S_START) || (state_q == S_CLR);
    assign rf_wen_o    = (state_q == S_WB) && !last_layer;
    assign rf_waddr_o  = rf_wen_o ? out_base + RF_AW'(j_q) : '0;
    assign out_valid_o = (state_q == S_WB) && last_layer;
    assign out_idx_o   = out_valid_o ? 8'(j_q) : '0;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mlp_layer_sequencer
//
// Scoreboard bench: each frame start pushes the full expected trace (operand
// and weight addresses per MAC, writeback addresses, final-layer indices,
// start and done cycles) into queues; the per-cycle monitor pops and compares
// them as the sequencer produces them. A second instance covers a one-layer
// configuration.
// ---------------------------------------------------------------------------
module tb_mlp_layer_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       frame_ready;
    logic [6:0] frame_base;
    logic       busy, done, rf_ren, mac_en, acc_clr, rf_wen, out_valid;
    logic [2:0] layer;
    logic [6:0] dmem_addr, rf_raddr, rf_waddr;
    logic [12:0] wmem_addr;
    logic [7:0] out_idx;

    logic       s_frame_ready;
    logic [6:0] s_frame_base;
    logic       s_busy, s_done, s_rf_ren, s_mac_en, s_acc_clr, s_rf_wen, s_out_valid;
    logic [2:0] s_layer;
    logic [6:0] s_dmem_addr, s_rf_raddr, s_rf_waddr;
    logic [12:0] s_wmem_addr;
    logic [7:0] s_out_idx;

    mlp_layer_sequencer dut (
        .clk_i(clk), .rst_i(rst), .frame_ready_i(frame_ready), .frame_base_i(frame_base),
        .busy_o(busy), .done_o(done), .layer_o(layer), .dmem_addr_o(dmem_addr),
        .rf_raddr_o(rf_raddr), .rf_ren_o(rf_ren), .wmem_addr_o(wmem_addr),
        .mac_en_o(mac_en), .acc_clr_o(acc_clr), .rf_wen_o(rf_wen), .rf_waddr_o(rf_waddr),
        .out_valid_o(out_valid), .out_idx_o(out_idx)
    );

    mlp_layer_sequencer #(
        .NUM_LAYERS(1), .LAYER_SIZES(16'h0203)
    ) dut_small (
        .clk_i(clk), .rst_i(rst), .frame_ready_i(s_frame_ready), .frame_base_i(s_frame_base),
        .busy_o(s_busy), .done_o(s_done), .layer_o(s_layer), .dmem_addr_o(s_dmem_addr),
        .rf_raddr_o(s_rf_raddr), .rf_ren_o(s_rf_ren), .wmem_addr_o(s_wmem_addr),
        .mac_en_o(s_mac_en), .acc_clr_o(s_acc_clr), .rf_wen_o(s_rf_wen), .rf_waddr_o(s_rf_waddr),
        .out_valid_o(s_out_valid), .out_idx_o(s_out_idx)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    int exp_op[$];
    int exp_wm[$];
    int exp_wb[$];
    int exp_out[$];
    int exp_start[$];
    int exp_done[$];

    int p_dmem = 0, p_rf_raddr = 0, p_wm = 0, last_wm = -1;
    bit p_rf_ren = 0, p_busy = 0, p_wb = 0;

    function automatic int size_of(input int k);
        case (k)
            0: return 48;
            1: return 60;
            2: return 24;
            3: return 11;
            default: return 2;
        endcase
    endfunction

    // Expected trace of one default frame accepted in cycle acc_cyc.
    task automatic push_frame(input int acc_cyc, input int base);
        int wm, lat, nin, nout;
        wm  = 0;
        lat = 1;
        exp_start.push_back(acc_cyc + 1);
        for (int k = 0; k < 4; k++) begin
            nin  = size_of(k);
            nout = size_of(k + 1);
            lat += nout * (nin + 3);
            for (int j = 0; j < nout; j++) begin
                for (int i = 0; i < nin; i++) begin
                    if (k == 0) exp_op.push_back((base + i) % 128);
                    else        exp_op.push_back(65536 + (((k % 2) == 1) ? 0 : 64) + i);
                    exp_wm.push_back(wm);
                    wm++;
                end
                if (k < 3) exp_wb.push_back((((k % 2) == 0) ? 0 : 64) + j);
                else       exp_out.push_back(j);
            end
        end
        exp_done.push_back(acc_cyc + lat + 1);
    endtask

    // One clock: sample at the falling edge and score whatever the DUT produced.
    task automatic cycle();
        int op_a, op_e, wm_e, e;
        @(negedge clk);
        cyc++;
        if (mac_en === 1'b1) begin
            tests_run++;
            if (exp_op.size() == 0) begin
                tests_failed++;
                $display("FAIL mac_issue cyc=%0d: mac_en high, no issue expected", cyc);
            end else begin
                op_e = exp_op.pop_front();
                wm_e = exp_wm.pop_front();
                op_a = p_rf_ren ? (65536 + p_rf_raddr) : p_dmem;
                if (op_a !== op_e || p_wm !== wm_e) begin
                    tests_failed++;
                    $display("FAIL mac_issue cyc=%0d: operand %0d wmem %0d, want operand %0d wmem %0d",
                             cyc, op_a, p_wm, op_e, wm_e);
                end
            end
            last_wm = p_wm;
        end
        if (rf_wen === 1'b1) begin
            tests_run++;
            e = (exp_wb.size() == 0) ? -1 : exp_wb.pop_front();
            if (int'(rf_waddr) !== e) begin
                tests_failed++;
                $display("FAIL rf_writeback cyc=%0d: waddr %0d, want %0d", cyc, rf_waddr, e);
            end
        end
        if (out_valid === 1'b1) begin
            tests_run++;
            e = (exp_out.size() == 0) ? -1 : exp_out.pop_front();
            if (int'(out_idx) !== e) begin
                tests_failed++;
                $display("FAIL out_idx cyc=%0d: idx %0d, want %0d", cyc, out_idx, e);
            end
        end
        if (p_wb) begin
            tests_run++;
            if (acc_clr !== 1'b1) begin
                tests_failed++;
                $display("FAIL acc_clr_after_wb cyc=%0d: acc_clr %b, want 1", cyc, acc_clr);
            end
        end
        if (busy === 1'b1 && !p_busy) begin
            tests_run++;
            e = (exp_start.size() == 0) ? -1 : exp_start.pop_front();
            if (cyc !== e || acc_clr !== 1'b1) begin
                tests_failed++;
                $display("FAIL frame_start cyc=%0d: acc_clr %b, want start at %0d with acc_clr 1",
                         cyc, acc_clr, e);
            end
        end
        if (done === 1'b1) begin
            tests_run++;
            e = (exp_done.size() == 0) ? -1 : exp_done.pop_front();
            if (cyc !== e || busy !== 1'b0 || layer !== 3'd0) begin
                tests_failed++;
                $display("FAIL frame_done cyc=%0d: busy %b layer %0d, want done at %0d busy 0 layer 0",
                         cyc, busy, layer, e);
            end
            $display("[TB] frame done at cyc %0d", cyc);
        end
        p_dmem     = int'(dmem_addr);
        p_rf_raddr = int'(rf_raddr);
        p_rf_ren   = (rf_ren === 1'b1);
        p_wm       = int'(wmem_addr);
        p_busy     = (busy === 1'b1);
        p_wb       = (rf_wen === 1'b1) || (out_valid === 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        frame_ready = 1'b0;
        s_frame_ready = 1'b0;
        exp_op.delete(); exp_wm.delete(); exp_wb.delete();
        exp_out.delete(); exp_start.delete(); exp_done.delete();
        repeat (3) cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        cycle();
        tests_run++;
        if ({busy, done, layer, dmem_addr, rf_raddr, rf_ren, wmem_addr, mac_en, acc_clr,
             rf_wen, rf_waddr, out_valid, out_idx} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: busy %b done %b layer %0d wmem %0d mac_en %b acc_clr %b, want all 0",
                     busy, done, layer, wmem_addr, mac_en, acc_clr);
        end
        tests_run++;
        if ({s_busy, s_done, s_layer, s_dmem_addr, s_rf_raddr, s_rf_ren, s_wmem_addr, s_mac_en,
             s_acc_clr, s_rf_wen, s_rf_waddr, s_out_valid, s_out_idx} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs_small: busy %b layer %0d wmem %0d, want all 0",
                     s_busy, s_layer, s_wmem_addr);
        end
        for (int n = 0; n < 20; n++) begin
            cycle();
            tests_run++;
            if (busy !== 1'b0 || acc_clr !== 1'b0 || wmem_addr !== 13'd0) begin
                tests_failed++;
                $display("FAIL idle_quiet cyc=%0d: busy %b acc_clr %b wmem %0d, want 0 0 0",
                         cyc, busy, acc_clr, wmem_addr);
            end
        end
    endtask

    task automatic check_drained(input string name);
        tests_run++;
        if (exp_op.size() + exp_wb.size() + exp_out.size() + exp_start.size() + exp_done.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_drained: left op %0d wb %0d out %0d start %0d done %0d, want all 0",
                     name, exp_op.size(), exp_wb.size(), exp_out.size(), exp_start.size(), exp_done.size());
        end
    endtask

    task automatic test_frame();
        int c0;
        do_reset();
        last_wm = -1;
        c0 = cyc;
        frame_base = 7'd7;
        frame_ready = 1'b1;
        push_frame(c0, 7);
        cycle();
        frame_ready = 1'b0;
        repeat (4899 + 4) cycle();
        check_drained("frame");
        tests_run++;
        if (last_wm !== 4605) begin
            tests_failed++;
            $display("FAIL final_wmem: last issued %0d, want 4605", last_wm);
        end
        tests_run++;
        if (wmem_addr !== 13'd0 || busy !== 1'b0 || layer !== 3'd0) begin
            tests_failed++;
            $display("FAIL after_done: wmem %0d busy %b layer %0d, want 0 0 0", wmem_addr, busy, layer);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        do_reset();
        c0 = cyc;
        frame_base = 7'd1;
        frame_ready = 1'b1;
        push_frame(c0, 1);
        push_frame(c0 + 5000, 1);
        repeat (5001) cycle();
        frame_ready = 1'b0;
        repeat (4899 + 5) cycle();
        check_drained("back_to_back");
    endtask

    task automatic test_pending();
        int c0;
        do_reset();
        c0 = cyc;
        frame_base = 7'd3;
        frame_ready = 1'b1;
        push_frame(c0, 3);
        push_frame(c0 + 5000, 20);
        cycle();
        frame_ready = 1'b0;
        repeat (9) cycle();
        frame_base = 7'd20;
        frame_ready = 1'b1;
        cycle();
        frame_ready = 1'b0;
        repeat (9) cycle();
        frame_ready = 1'b1;
        cycle();
        frame_ready = 1'b0;
        while (cyc < c0 + 5000 + 4899 + 5) cycle();
        check_drained("pending");
    endtask

    task automatic test_abort();
        int c0;
        do_reset();
        c0 = cyc;
        frame_base = 7'd0;
        frame_ready = 1'b1;
        push_frame(c0, 0);
        cycle();
        frame_ready = 1'b0;
        repeat (1999) cycle();
        tests_run++;
        if (busy !== 1'b1 || layer !== 3'd0) begin
            tests_failed++;
            $display("FAIL abort_pre: busy %b layer %0d, want 1 0", busy, layer);
        end
        rst = 1'b1;
        exp_op.delete(); exp_wm.delete(); exp_wb.delete();
        exp_out.delete(); exp_start.delete(); exp_done.delete();
        cycle();
        rst = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || mac_en !== 1'b0 || wmem_addr !== 13'd0) begin
            tests_failed++;
            $display("FAIL abort_idle: busy %b done %b mac_en %b wmem %0d, want 0 0 0 0",
                     busy, done, mac_en, wmem_addr);
        end
        repeat (3000) cycle();
        c0 = cyc;
        frame_base = 7'd9;
        frame_ready = 1'b1;
        push_frame(c0, 9);
        cycle();
        frame_ready = 1'b0;
        repeat (200) cycle();
        tests_run++;
        if (exp_wm.size() >= 4606) begin
            tests_failed++;
            $display("FAIL restart_progress: %0d weights pending, want fewer than 4606", exp_wm.size());
        end
        do_reset();
    endtask

    task automatic test_small();
        int c0, e, dones;
        int sq[$];
        c0 = cyc;
        dones = 0;
        sq.push_back(0);
        sq.push_back(1);
        s_frame_base = 7'd5;
        s_frame_ready = 1'b1;
        repeat (30) begin
            cycle();
            s_frame_ready = 1'b0;
            if (s_out_valid === 1'b1) begin
                tests_run++;
                e = (sq.size() == 0) ? -1 : sq.pop_front();
                if (int'(s_out_idx) !== e) begin
                    tests_failed++;
                    $display("FAIL small_out_idx cyc=%0d: idx %0d, want %0d", cyc, s_out_idx, e);
                end
            end
            if (s_rf_wen === 1'b1 || s_rf_ren === 1'b1) begin
                tests_run++;
                tests_failed++;
                $display("FAIL small_no_rf cyc=%0d: rf_wen %b rf_ren %b, want 0 0", cyc, s_rf_wen, s_rf_ren);
            end
            if (s_done === 1'b1) begin
                dones++;
                tests_run++;
                if (cyc - c0 !== 14) begin
                    tests_failed++;
                    $display("FAIL small_done: latency %0d, want 14", cyc - c0);
                end
                $display("[TB] small frame done at cyc %0d", cyc);
            end
        end
        tests_run++;
        if (sq.size() != 0 || dones != 1) begin
            tests_failed++;
            $display("FAIL small_complete: idx left %0d dones %0d, want 0 and 1", sq.size(), dones);
        end
    endtask

    initial begin
        rst = 1'b1;
        frame_ready = 1'b0;
        frame_base = '0;
        s_frame_ready = 1'b0;
        s_frame_base = '0;
        test_reset();
        test_frame();
        test_back_to_back();
        test_pending();
        test_abort();
        test_small();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
